uart_rx_oversampler: RTL and testbench

- Parametrised bit-sampling stage for the UART receiver, placed between the edge/bit counter and the deserializer/parity/stop checkers.
- Captures NUM_SAMPLES consecutive RX samples centred on the middle edge of each bit period and resolves the bit by majority vote.
- Emits a one-cycle valid strobe and a per-bit noise indication.
- Detects prescale values too small to hold the sampling window.

---
 rtl/uart_rx_pkg.sv | 30 +++
 rtl/uart_majority_vote.sv | 27 ++
 rtl/uart_rx_oversampler.sv | 94 +++++++++
 tb/tb_uart_rx_oversampler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and sampling-window arithmetic for the UART receive path.
// Used by the bit sampler, the edge counter and the start-glitch checker.
package uart_rx_pkg;

  localparam int DEFAULT_PRESCALE_W = 6;
  localparam int MAX_SAMPLES        = 7;
  localparam int CALC_W             = 16;

  typedef struct packed {
    logic [CALC_W-1:0] first;
    logic [CALC_W-1:0] last;
    logic              cfg_err;
  } win_bounds_t;

  // Window of num_samples edges centred on edge (prescale/2 - 1).
  // first/last are only meaningful when cfg_err is clear.
  function automatic win_bounds_t calc_window(input logic [CALC_W-1:0] prescale,
                                              input int                num_samples);
    win_bounds_t       w;
    logic [CALC_W-1:0] half;
    logic [CALC_W-1:0] h;
    h         = CALC_W'((num_samples - 1) / 2);
    half      = prescale >> 1;
    w.cfg_err = (half < h + CALC_W'(1));
    w.first   = half - CALC_W'(1) - h;
    w.last    = half - CALC_W'(1) + h;
    return w;
  endfunction

endpackage

// File: rtl/uart_majority_vote.sv
// Combinational majority vote over an N-bit sample vector, plus an all-equal flag.
// Also used by the start-bit glitch check.
module uart_majority_vote #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_vec,
  output logic         o_majority,
  output logic         o_all_equal
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] w_ones;

  // NOTE: blocking assignments here build a running sum inside one evaluation;
  // non-blocking would leave only the last term.
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < N; i++) begin
      w_ones = w_ones + CW'(i_vec[i]);
    end
  end

  assign o_majority  = (w_ones > CW'(N / 2));
  assign o_all_equal = (&i_vec) | ~(|i_vec);

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART bit sampler: captures NUM_SAMPLES RX samples around the bit centre and
// resolves the bit by majority vote, flagging disagreement as noise.
module uart_rx_oversampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W  = DEFAULT_PRESCALE_W,
  parameter int NUM_SAMPLES = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic                  rx_in,
  input  logic                  data_samp_en,
  output logic                  sample_bit,
  output logic                  sample_valid,
  output logic                  noise_flag,
  output logic                  cfg_err
);

  localparam int              CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(NUM_SAMPLES);

  win_bounds_t            w_win;
  logic                   w_in_win;
  logic                   w_capture;
  logic                   w_at_last;
  logic [NUM_SAMPLES-1:0] w_vec_next;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_maj;
  logic                   w_all_eq;

  logic [NUM_SAMPLES-1:0] r_vec;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_bit;
  logic                   r_valid;
  logic                   r_noise;

  assign w_win     = calc_window(CALC_W'(prescale), NUM_SAMPLES);
  assign cfg_err   = w_win.cfg_err;
  assign w_in_win  = (CALC_W'(edge_cnt) >= w_win.first) && (CALC_W'(edge_cnt) <= w_win.last);
  assign w_capture = data_samp_en && !w_win.cfg_err && w_in_win;
  assign w_at_last = (CALC_W'(edge_cnt) == w_win.last);

  // Vote order is irrelevant, so each sample lands at the slot given by the count.
  always_comb begin
    w_vec_next = r_vec;
    w_cnt_next = r_cnt;
    if (r_cnt != FULL) begin
      w_vec_next = r_vec | (NUM_SAMPLES'(rx_in) << r_cnt);
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  uart_majority_vote #(.N(NUM_SAMPLES)) u_vote (
    .i_vec       (w_vec_next),
    .o_majority  (w_maj),
    .o_all_equal (w_all_eq)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_vec   <= '0;
      r_cnt   <= '0;
      r_bit   <= 1'b0;
      r_valid <= 1'b0;
      r_noise <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!w_capture) begin
        r_vec <= '0;
        r_cnt <= '0;
      end else if (w_at_last) begin
        r_vec <= '0;
        r_cnt <= '0;
        if (w_cnt_next == FULL) begin
          r_bit   <= w_maj;
          r_noise <= !w_all_eq;
          r_valid <= 1'b1;
        end
      end else begin
        r_vec <= w_vec_next;
        r_cnt <= w_cnt_next;
      end
    end
  end

  assign sample_bit   = r_bit;
  assign sample_valid = r_valid;
  assign noise_flag   = r_noise;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Scoreboard bench for uart_rx_oversampler with NUM_SAMPLES = 1, 3 and 5 instances
// sharing one stimulus bus; only the selected instance sees data_samp_en.
module tb_uart_rx_oversampler;

  localparam int PW = 6;
  localparam int NS [3] = '{1, 3, 5};

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [PW-1:0] edge_cnt = '0;
  logic          rx_in = 1'b0;
  logic          en = 1'b0;
  int            sel = 0;

  logic [2:0] en_v, sv, sb, sn, ce;

  assign en_v[0] = en && (sel == 0);
  assign en_v[1] = en && (sel == 1);
  assign en_v[2] = en && (sel == 2);

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_rx_oversampler #(.PRESCALE_W(PW), .NUM_SAMPLES(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .prescale(prescale), .edge_cnt(edge_cnt), .rx_in(rx_in),
    .data_samp_en(en_v[0]), .sample_bit(sb[0]), .sample_valid(sv[0]),
    .noise_flag(sn[0]), .cfg_err(ce[0]));

  uart_rx_oversampler #(.PRESCALE_W(PW), .NUM_SAMPLES(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .prescale(prescale), .edge_cnt(edge_cnt), .rx_in(rx_in),
    .data_samp_en(en_v[1]), .sample_bit(sb[1]), .sample_valid(sv[1]),
    .noise_flag(sn[1]), .cfg_err(ce[1]));

  uart_rx_oversampler #(.PRESCALE_W(PW), .NUM_SAMPLES(5)) u_dut5 (
    .CLK(CLK), .RST(RST), .prescale(prescale), .edge_cnt(edge_cnt), .rx_in(rx_in),
    .data_samp_en(en_v[2]), .sample_bit(sb[2]), .sample_valid(sv[2]),
    .noise_flag(sn[2]), .cfg_err(ce[2]));

  typedef struct {
    logic b;
    logic n;
    int   due;
  } exp_t;

  exp_t q [3][$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Every strobe must match the head of its queue on the due cycle;
  // a due entry with no strobe, or a strobe with nothing queued, is an error.
  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (sv[i]) begin
        checks++;
        if (q[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe dut%0d: sample_valid=1 at cycle %0d, required 0", i, cyc);
        end else begin
          mon_e = q[i].pop_front();
          if (sb[i] !== mon_e.b || sn[i] !== mon_e.n || cyc != mon_e.due) begin
            errors++;
            $display("FAIL strobe dut%0d: got bit=%b noise=%b cycle=%0d, required bit=%b noise=%b cycle=%0d",
                     i, sb[i], sn[i], cyc, mon_e.b, mon_e.n, mon_e.due);
          end
        end
      end else if (q[i].size() != 0 && q[i][0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_strobe dut%0d: sample_valid=0 at cycle %0d, required 1", i, cyc);
        void'(q[i].pop_front());
      end
    end
  end

  // One bit period on instance idx. win[i] is rx at window edge F+i; enable is
  // high for edges en_lo..en_hi; rst_edge >= 0 asserts reset at that edge.
  task automatic run_bit(input int idx, input int ps, input logic [7:0] win, input logic outside,
                         input int en_lo, input int en_hi, input bit exp_s, input logic eb,
                         input logic enz, input int rst_edge);
    int   h, f, l;
    exp_t e;
    h   = (NS[idx] - 1) / 2;
    f   = ps / 2 - 1 - h;
    l   = ps / 2 - 1 + h;
    sel = idx;
    for (int k = 0; k < ps; k++) begin
      @(posedge CLK);
      #2;
      prescale = PW'(ps);
      edge_cnt = PW'(k);
      rx_in    = (k >= f && k <= l) ? win[k - f] : outside;
      en       = (k >= en_lo && k <= en_hi);
      if (k == l && exp_s) begin
        e.b   = eb;
        e.n   = enz;
        e.due = cyc + 1;
        q[idx].push_back(e);
      end
      if (k == rst_edge) begin
        RST = 1'b0;
        #1;
        checks++;
        if ({sb[idx], sv[idx], sn[idx]} !== 3'b000) begin
          errors++;
          $display("FAIL async_reset dut%0d: bit/valid/noise=%b%b%b, required 000",
                   idx, sb[idx], sv[idx], sn[idx]);
        end
      end
    end
    if (rst_edge >= 0) begin
      @(posedge CLK);
      #2;
      RST = 1'b1;
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    RST      = 1'b0;
    prescale = '0;
    repeat (3) @(posedge CLK);
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({sb[i], sv[i], sn[i]} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: bit/valid/noise=%b%b%b, required 000", i, sb[i], sv[i], sn[i]);
      end
    end
    checks++;
    if (ce !== 3'b111) begin
      errors++;
      $display("FAIL cfg_err_prescale0: got %b, required 111", ce);
    end
    RST = 1'b1;
  endtask

  task automatic test_clean_bits();
    run_bit(1, 16, 8'b111, 1'b0, 0, 15, 1, 1'b1, 1'b0, -1);
    run_bit(1, 16, 8'b000, 1'b1, 0, 15, 1, 1'b0, 1'b0, -1);
    run_bit(1, 16, 8'b111, 1'b0, 0, 15, 1, 1'b1, 1'b0, -1);
  endtask

  task automatic test_glitch();
    run_bit(1, 8,  8'b101,   1'b0, 0, 7,  1, 1'b1, 1'b1, -1);
    run_bit(2, 16, 8'b00110, 1'b1, 0, 15, 1, 1'b0, 1'b1, -1);
  endtask

  task automatic test_cfg_err();
    sel      = 2;
    prescale = PW'(4);
    #1;
    checks++;
    if (ce[2] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_n5_ps4: got %b, required 1", ce[2]);
    end
    for (int b = 0; b < 10; b++) begin
      run_bit(2, 4, 8'b11111, 1'b1, 0, 3, 0, 1'b0, 1'b0, -1);
    end
    prescale = PW'(8);
    #1;
    checks++;
    if (ce[2] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_n5_ps8: got %b, required 0", ce[2]);
    end
    run_bit(2, 8, 8'b11111, 1'b0, 0, 7, 1, 1'b1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    int         ones;
    for (int b = 0; b < 6; b++) begin
      w    = 8'($urandom_range(0, 31));
      ones = $countones(w[4:0]);
      run_bit(2, 8, w, 1'b0, 0, 7, 1, (ones > 2), !(ones == 0 || ones == 5), -1);
    end
  endtask

  task automatic test_late_enable();
    run_bit(1, 16, 8'b111, 1'b1, 7, 15, 0, 1'b0, 1'b0, -1);
    run_bit(1, 16, 8'b000, 1'b1, 0, 15, 1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_enable_drop_reset();
    run_bit(1, 16, 8'b101, 1'b0, 0, 15, 1, 1'b1, 1'b1, -1);
    run_bit(1, 16, 8'b000, 1'b0, 0, 6,  0, 1'b0, 1'b0, -1);
    checks++;
    if (sb[1] !== 1'b1 || sn[1] !== 1'b1) begin
      errors++;
      $display("FAIL hold_after_drop: bit=%b noise=%b, required bit=1 noise=1", sb[1], sn[1]);
    end
    run_bit(1, 16, 8'b111, 1'b0, 0, 15, 0, 1'b0, 1'b0, 7);
    run_bit(1, 16, 8'b111, 1'b0, 0, 15, 1, 1'b1, 1'b0, -1);
  endtask

  task automatic test_hold();
    run_bit(1, 16, 8'b111, 1'b0, 0, 15, 1, 1'b1, 1'b0, -1);
    sel = 1;
    en  = 1'b1;
    for (int k = 9; k < 16 + 6; k++) begin
      @(posedge CLK);
      #2;
      edge_cnt = PW'(k % 16);
      rx_in    = k[0];
    end
    @(negedge CLK);
    checks++;
    if (sb[1] !== 1'b1 || sn[1] !== 1'b0) begin
      errors++;
      $display("FAIL hold_outside_window: bit=%b noise=%b, required bit=1 noise=0", sb[1], sn[1]);
    end
    en = 1'b0;
  endtask

  task automatic test_single_sample();
    run_bit(0, 8, 8'b1, 1'b0, 0, 7, 1, 1'b1, 1'b0, -1);
    run_bit(0, 8, 8'b0, 1'b1, 0, 7, 1, 1'b0, 1'b0, -1);
    prescale = PW'(2);
    #1;
    checks++;
    if (ce[0] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_n1_ps2: got %b, required 0", ce[0]);
    end
    run_bit(0, 2, 8'b1, 1'b0, 0, 1, 1, 1'b1, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_clean_bits();
    test_glitch();
    test_cfg_err();
    test_back_to_back();
    test_late_enable();
    test_enable_drop_reset();
    test_hold();
    test_single_sample();
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        errors++;
        $display("FAIL pending_strobes dut%0d: %0d outstanding, required 0", i, q[i].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
